// File: rtl/shift_sequencer_if.sv
// Purpose: handshake and data bundle between a requester and shift_sequencer.
// Latency: none, wires only.
// Backpressure: none; start is only honoured while busy is low.
// Ports: i_start/i_a/i_shamt carry the request, o_busy/o_done/o_s carry status and result.
interface shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [SHW-1:0]   i_shamt;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_s;

  // The requester drives the request and observes status.
  modport master (
    output i_start, i_a, i_shamt,
    input  o_busy, o_done, o_s
  );

  // The shifter consumes the request and drives status.
  modport slave (
    input  i_start, i_a, i_shamt,
    output o_busy, o_done, o_s
  );
endinterface

// File: rtl/shift_sequencer.sv
// Purpose: S = A << SHAMT computed iteratively with one shift-by-2 stage plus a shift-by-1 stage for odd amounts.
// Latency: done rises in the cycle after edge ceil(SHAMT/2)+1, counting the accepted start edge as edge 1.
// Backpressure: start is sampled only while idle; requests during SHIFT or DONE are dropped, not queued.
// Ports:
//   i_clk   rising-edge clock
//   i_rst   asynchronous active-high reset, aborts any operation without a done pulse
//   io_sq   slave side of shift_sequencer_if (start/A/SHAMT in, busy/done/S out)
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  shift_sequencer_if.slave  io_sq
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_rem;
  logic [WIDTH-1:0] r_s;

  // The two shared shift stages; bits leaving the top are discarded.
  logic [WIDTH-1:0] w_acc_sh2;
  logic [WIDTH-1:0] w_acc_sh1;
  logic             w_rem_ge2;
  logic             w_rem_eq2;

  assign w_acc_sh2 = r_acc << 2;
  assign w_acc_sh1 = r_acc << 1;
  assign w_rem_ge2 = (r_rem >= SHW'(2));
  assign w_rem_eq2 = (r_rem == SHW'(2));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_s     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_sq.i_start) begin
            r_acc <= io_sq.i_a;
            r_rem <= io_sq.i_shamt;
            if (io_sq.i_shamt == '0) begin
              // Zero shift: the operand is the result, publish it now.
              r_s     <= io_sq.i_a;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          if (w_rem_ge2) begin
            r_acc <= w_acc_sh2;
            r_rem <= r_rem - SHW'(2);
            if (w_rem_eq2) begin
              r_s     <= w_acc_sh2;
              r_state <= ST_DONE;
            end
          end else begin
            // Only an odd remainder of 1 lands here; rem==0 never enters SHIFT.
            r_acc   <= w_acc_sh1;
            r_rem   <= '0;
            r_s     <= w_acc_sh1;
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_sq.o_busy = (r_state != ST_IDLE);
  assign io_sq.o_done = (r_state == ST_DONE);
  assign io_sq.o_s    = r_s;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shift_sequencer_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_sq (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted request yields A<<SHAMT after
  // ceil(SHAMT/2) further edges, then a single done cycle, then idle.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_s    = '0;
  logic [31:0] m_res  = '0;
  int          m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_s    = '0;
      m_left = 0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_s    = m_res;
      end
    end else if (bus.i_start) begin
      m_res  = bus.i_a << bus.i_shamt;
      m_left = (int'(bus.i_shamt) + 1) / 2;
      m_busy = 1'b1;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_s    = m_res;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", {31'd0, bus.o_busy}, {31'd0, m_busy});
      chk("done", {31'd0, bus.o_done}, {31'd0, m_done});
      chk("S",    bus.o_s, m_s);
      if (bus.o_done) n_done++;
    end
  end

  // Called at the negedge after the accept edge; counts edges until done.
  task automatic wait_done(output int edges, output int busy_cyc);
    bit seen;
    seen     = 1'b0;
    edges    = 1;
    busy_cyc = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.o_busy) busy_cyc++;
      if (bus.o_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      edges++;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
  endtask

  // Called at a negedge in IDLE; returns at the negedge after DONE (IDLE again).
  task automatic run_op(input logic [31:0] a, input logic [4:0] sh,
                        input logic [31:0] exp_s, input int exp_edges);
    int edges, bc;
    bus.i_start = 1'b1;
    bus.i_a     = a;
    bus.i_shamt = sh;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done(edges, bc);
    chk("latency", edges, exp_edges);
    chk("busy_cycles", bc, exp_edges);
    chk("result", bus.o_s, exp_s);
    @(negedge clk);
  endtask

  int edges, bc, d0;

  initial begin
    bus.i_start = 1'b0;
    bus.i_a     = '0;
    bus.i_shamt = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_done", {31'd0, bus.o_done}, 32'd0);
    chk("rst_S",    bus.o_s, 32'd0);

    // Abort mid-SHIFT: A=1, SHAMT=31, reset after 5 edges.
    @(negedge clk);
    d0 = n_done;
    bus.i_start = 1'b1; bus.i_a = 32'd1; bus.i_shamt = 5'd31;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", {31'd0, bus.o_busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("abort_done", {31'd0, bus.o_done}, 32'd0);
    chk("abort_S",    bus.o_s, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("abort_no_done", n_done - d0, 32'd0);

    // Main function and boundaries.
    @(negedge clk);
    run_op(32'd3782,      5'd2,  32'd15128,     2);
    run_op(32'd3782,      5'd0,  32'd3782,      1);
    run_op(32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFE0, 4);
    run_op(32'd1,         5'd31, 32'h8000_0000, 17);
    run_op(32'h8000_0001, 5'd1,  32'h0000_0002, 2);
    run_op(32'h0000_00A5, 5'd8,  32'h0000_A500, 5);

    // Re-pulsed start while busy is ignored.
    d0 = n_done;
    bus.i_start = 1'b1; bus.i_a = 32'd7; bus.i_shamt = 5'd4;
    @(negedge clk);
    bus.i_a = 32'd5; bus.i_shamt = 5'd0;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done(edges, bc);
    chk("ignore_S", bus.o_s, 32'd112);
    repeat (3) @(negedge clk);
    #1 chk("ignore_one_done", n_done - d0, 32'd1);

    // Start held through DONE is taken in the following IDLE cycle.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_a = 32'd3; bus.i_shamt = 5'd2;
    @(negedge clk);
    wait_done(edges, bc);
    chk("held_first_S", bus.o_s, 32'd12);
    bus.i_a = 32'd9; bus.i_shamt = 5'd1;
    @(negedge clk);
    chk("held_idle_busy", {31'd0, bus.o_busy}, 32'd0);
    @(negedge clk);
    chk("held_accept_busy", {31'd0, bus.o_busy}, 32'd1);
    bus.i_start = 1'b0;
    wait_done(edges, bc);
    chk("held_second_S", bus.o_s, 32'd18);
    @(negedge clk);

    // Back-to-back, each issued as soon as busy drops.
    d0 = n_done;
    run_op(32'd1, 5'd3, 32'd8, 3);
    run_op(32'd2, 5'd2, 32'd8, 2);
    #1 chk("b2b_two_done", n_done - d0, 32'd2);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle variable left shifter that reuses a fixed shift-left-by-2 stage iteratively, plus a shift-by-1 stage for odd amounts.
- Computes S = A << SHAMT, shifting 2 bits per cycle, with a start/busy/done handshake.
- Shares one small shift stage in place of a full barrel shifter; serves the multi-cycle datapath where area matters more than latency.

Parameters:
- WIDTH, 32, data width of A and S.
- SHW, 5, width of SHAMT; legal shift range is 0 to 2^SHW-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; returns the block to IDLE
- start  input  1  request pulse; sampled only in IDLE
- A  input  WIDTH  operand, captured at the accepted start edge
- SHAMT  input  SHW  shift amount, captured at the accepted start edge
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse marking S valid with a new result
- S  output  WIDTH  registered result; holds its value until the next result completes

Behaviour:
- Reset (asynchronous, any state): state=IDLE, acc=0, rem=0, S=0, busy=0, done=0. An operation in flight is aborted with no done pulse.
- Internal registers: acc[WIDTH-1:0] and rem[SHW-1:0].
- States: IDLE, SHIFT, DONE. Outputs are Moore-style:
  - busy = (state != IDLE)
  - done = (state == DONE)
- IDLE:
  - start=1 at an edge: acc<=A, rem<=SHAMT.
  - Next state is DONE if SHAMT==0, otherwise SHIFT.
  - If SHAMT==0, also S<=A at that same edge.
  - start=0: remain in IDLE.
- SHIFT, each edge:
  - rem>=2: acc<=acc<<2 (zero-fill the low 2 bits, discard the top 2), rem<=rem-2. If rem==2, also S<=acc<<2 and go to DONE.
  - rem==1: acc<=acc<<1, S<=acc<<1, go to DONE.
  - rem==0 is unreachable in SHIFT.
- DONE: lasts exactly one cycle; the next edge goes to IDLE unconditionally.
- start handling:
  - Ignored in SHIFT and DONE (no queuing).
  - A start asserted during the DONE cycle is lost; the requester re-asserts it once busy=0.
- Latency: done is high in the cycle following edge number ceil(SHAMT/2)+1, counting the accepted start edge as edge 1.
  - Examples: SHAMT=0 gives 1 edge; 2 gives 2; 3 gives 3; 31 gives 17.
- Back-to-back throughput: one operation per ceil(SHAMT/2)+2 cycles. start is re-accepted in the IDLE cycle after DONE.
- S update rule: S changes only on DONE entry. It is not disturbed by a new start, and reads the previous result until the new done.
- Arithmetic:
  - Logical shift; bits shifted past WIDTH-1 are lost.
  - No overflow flag.
  - SHAMT >= WIDTH cannot occur with the defaults.

Test Plan:
- reset=1, then release: busy=0, done=0, S=0. Then reset=1 mid-SHIFT (A=1, SHAMT=31, after 5 edges): busy=0 immediately and asynchronously, no done pulse, S unchanged from its value before reset.
- A=3782, SHAMT=2, start for 1 cycle: done is high for exactly 1 cycle after 2 edges, S=15128 (A*4), busy=1 for 2 cycles.
- A=3782, SHAMT=0: done after 1 edge, S=3782. A=0xFFFFFFFF, SHAMT=5: done after 4 edges (shift2, shift2, shift1), S=0xFFFFFFE0.
- A=1, SHAMT=31: done after 17 edges, S=0x80000000. A=0x80000001, SHAMT=1: S=0x00000002 (MSB discarded).
- start re-pulsed with A=5 while busy during A=7, SHAMT=4: the second request is ignored, S=112, and only one done pulse occurs. A start held high through DONE is accepted in the following IDLE cycle.
- Back-to-back: A=1/SHAMT=3 then A=2/SHAMT=2, each issued as soon as busy=0. S=8 after the first done, S stays 8 through the second operation, then S=8 again at the second done; exactly two done pulses.
